// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: segment constants, scan states
// and the hex-to-segment table.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;

  typedef enum logic [1:0] {OFF, BLANK, SHOW} scan_state_e;

  // Returns segments gfedcba, 1 = lit.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex7_dec.sv
// Combinational nibble to 7-segment decoder (gfedcba, 1 = lit).
module seg_hex7_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  always_comb seg7 = hex7(nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with double-buffered digit data
// and a blanking gap at the start of every digit slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLANK_CYC   = 500,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          DIG_ACT_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [4*N_DIG-1:0] wr_data,
  input  logic [N_DIG-1:0]   wr_dp,
  input  logic [N_DIG-1:0]   wr_blank,
  output logic [7:0]         seg,
  output logic [N_DIG-1:0]   dig,
  output logic               frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIG);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
  localparam logic [7:0]       SEG_IDLE  = SEG_OFF ^ {8{SEG_ACT_LOW}};
  localparam logic [N_DIG-1:0] DIG_IDLE  = {N_DIG{DIG_ACT_LOW}};

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_evt;

  logic [4*N_DIG-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [N_DIG-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [N_DIG-1:0]   act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
  logic               pend_q, pend_d;
  logic               wr_acc;

  logic [7:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   dig_q, dig_d;
  logic               tick_q, tick_d;
  logic [6:0]         seg7;
  logic [3:0]         nib;

  assign wr_ready   = ~pend_q;
  assign wr_acc     = wr_valid & wr_ready;
  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = tick_q;
  assign nib        = act_data_q[{idx_q, 2'b00} +: 4];

  seg_hex7_dec u_dec (
    .nib  (nib),
    .seg7 (seg7)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_evt = 1'b0;
    if (!en) begin
      state_d = OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == OFF) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d     = '0;
          frame_evt = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      state_d = (cnt_d < CNT_BLANK) ? BLANK : SHOW;
    end
  end

  // Pending data is also committed while disabled so a write cannot stall with no frames.
  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    pend_d      = pend_q;
    if (pend_q && (frame_evt || !en)) begin
      act_data_d  = sh_data_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      pend_d      = 1'b0;
    end
    if (wr_acc) begin
      if (en) begin
        sh_data_d  = wr_data;
        sh_dp_d    = wr_dp;
        sh_blank_d = wr_blank;
        pend_d     = 1'b1;
      end else begin
        act_data_d  = wr_data;
        act_dp_d    = wr_dp;
        act_blank_d = wr_blank;
      end
    end
  end

  always_comb begin
    logic [7:0]       seg_raw;
    logic [N_DIG-1:0] dig_raw;
    seg_raw = SEG_OFF;
    dig_raw = '0;
    if (en && state_q == SHOW && !act_blank_q[idx_q]) begin
      dig_raw = N_DIG'(1) << idx_q;
      seg_raw = {act_dp_q[idx_q], seg7};
    end
    seg_d  = seg_raw ^ {8{SEG_ACT_LOW}};
    dig_d  = dig_raw ^ {N_DIG{DIG_ACT_LOW}};
    tick_d = frame_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '1;
      pend_q      <= 1'b0;
      seg_q       <= SEG_IDLE;
      dig_q       <= DIG_IDLE;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      tick_q      <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scan sequences, a hex decode table and
// randomized traffic compared against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned N_DIG     = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          FRAME     = N_DIG * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_blank = '0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_tick;

  seg_scan_ctrl #(
    .N_DIG       (N_DIG),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .SEG_ACT_LOW (1'b0),
    .DIG_ACT_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_blank   (wr_blank),
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic [7:0] exp_seg;
  } hex_vec_t;
  hex_vec_t vecs [16];

  // Reference model: position within the frame since enable (-1 = dark), plus buffers.
  int          m_pos;
  logic [15:0] m_data, m_sh_data;
  logic [3:0]  m_dp, m_sh_dp, m_blank, m_sh_blank;
  logic        m_pend;
  logic [7:0]  m_seg;
  logic [3:0]  m_dig;
  logic        m_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = -1;
    m_data = '0; m_dp = '0; m_blank = '1;
    m_sh_data = '0; m_sh_dp = '0; m_sh_blank = '1;
    m_pend = 1'b0;
    m_seg = '0; m_dig = '0; m_tick = 1'b0;
  endtask

  task automatic model_commit();
    m_data = m_sh_data; m_dp = m_sh_dp; m_blank = m_sh_blank;
    m_pend = 1'b0;
  endtask

  task automatic model_edge();
    int   prev;
    int   d;
    int   c;
    logic acc;
    prev   = m_pos;
    acc    = wr_valid && !m_pend;
    m_seg  = '0;
    m_dig  = '0;
    m_tick = 1'b0;
    if (en) begin
      if (prev >= 0) begin
        d = prev / SCAN_DIV;
        c = prev % SCAN_DIV;
        if (c >= BLANK_CYC && !m_blank[d]) begin
          m_dig = 4'(1 << d);
          m_seg = {m_dp[d], hex_tab[m_data[d*4 +: 4]]};
        end
        m_tick = (prev == FRAME - 1);
        if (m_tick && m_pend) model_commit();
      end
      m_pos = (prev < 0) ? 0 : (prev + 1) % FRAME;
    end else begin
      m_pos = -1;
      if (m_pend) model_commit();
    end
    if (acc) begin
      if (en) begin
        m_sh_data = wr_data; m_sh_dp = wr_dp; m_sh_blank = wr_blank;
        m_pend = 1'b1;
      end else begin
        m_data = wr_data; m_dp = wr_dp; m_blank = wr_blank;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg", 32'(seg), 32'(m_seg));
    chk("dig", 32'(dig), 32'(m_dig));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
    chk("dig_onehot", 32'($countones(dig) <= 1), 32'd1);
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    wr_valid = 1'b1; wr_data = d; wr_dp = dp; wr_blank = bl;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic run_until_dig(input logic [3:0] mask, input string name);
    int n = 0;
    while (dig !== mask && n < 200) begin
      step();
      n++;
    end
    chk(name, 32'(dig), 32'(mask));
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(frame_tick), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_first, t_prev, n_tick;
    int hi [4];

    vecs = '{'{4'h0, 1'b0, 8'h3F}, '{4'h1, 1'b1, 8'h86}, '{4'h2, 1'b0, 8'h5B},
             '{4'h3, 1'b1, 8'hCF}, '{4'h4, 1'b0, 8'h66}, '{4'h5, 1'b1, 8'hED},
             '{4'h6, 1'b0, 8'h7D}, '{4'h7, 1'b1, 8'h87}, '{4'h8, 1'b0, 8'h7F},
             '{4'h9, 1'b1, 8'hEF}, '{4'hA, 1'b0, 8'h77}, '{4'hB, 1'b1, 8'hFC},
             '{4'hC, 1'b0, 8'h39}, '{4'hD, 1'b1, 8'hDE}, '{4'hE, 1'b0, 8'h79},
             '{4'hF, 1'b1, 8'hF1}};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_seg", 32'(seg), 32'h00);
    chk("reset_dig", 32'(dig), 32'h0);
    chk("reset_ready", 32'(wr_ready), 32'd1);
    chk("reset_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;

    // Load while disabled, then enable and follow the first two digit slots.
    step();
    do_write(16'h1234, 4'b0001, 4'b0000);
    chk("t2_ready_off", 32'(wr_ready), 32'd1);
    en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k >= 4 && k <= 9) begin
        chk("t2_seg_d0", 32'(seg), 32'hE6);
        chk("t2_dig_d0", 32'(dig), 32'h1);
      end else if (k >= 12) begin
        chk("t2_seg_d1", 32'(seg), 32'h4F);
        chk("t2_dig_d1", 32'(dig), 32'h2);
      end else begin
        chk("t2_seg_off", 32'(seg), 32'h00);
        chk("t2_dig_off", 32'(dig), 32'h0);
      end
    end

    // Steady scan over two whole frames.
    t_first = -1; t_prev = -1; n_tick = 0;
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (dig[i]) hi[i]++;
      if (frame_tick) begin
        if (t_prev >= 0) chk("t3_tick_period", 32'(k - t_prev), 32'(FRAME));
        t_prev = k;
        n_tick++;
      end
    end
    chk("t3_tick_count", 32'(n_tick), 32'd2);
    for (int i = 0; i < 4; i++) chk("t3_dig_duty", 32'(hi[i]), 32'd12);

    // Mid-frame write is held until the frame boundary.
    run_until_dig(4'b0010, "t4_reach_d1");
    do_write(16'hFFFF, 4'b0000, 4'b0000);
    chk("t4_ready_low", 32'(wr_ready), 32'd0);
    run_until_dig(4'b0100, "t4_reach_d2");
    chk("t4_old_d2", 32'(seg), 32'h5B);
    run_until_dig(4'b1000, "t4_reach_d3");
    chk("t4_old_d3", 32'(seg), 32'h06);
    wait_tick("t4_tick");
    chk("t4_ready_back", 32'(wr_ready), 32'd1);
    run_until_dig(4'b0001, "t4_reach_new_d0");
    chk("t4_new_d0", 32'(seg), 32'h71);

    // Disable during digit2 SHOW, then restart.
    run_until_dig(4'b0100, "t6_reach_d2");
    en = 1'b0;
    step();
    chk("t6_seg_off", 32'(seg), 32'h00);
    chk("t6_dig_off", 32'(dig), 32'h0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk("t6_no_tick", 32'(frame_tick), 32'd0);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t6_restart_dig", 32'(dig), (k == 4) ? 32'h1 : 32'h0);
    end
    chk("t6_restart_seg", 32'(seg), 32'h71);

    // Blank digit 2 only.
    do_write(16'h1234, 4'b0000, 4'b0100);
    wait_tick("t5_tick");
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (dig[i]) hi[i]++;
    end
    chk("t5_d0_lit", 32'(hi[0]), 32'd6);
    chk("t5_d1_lit", 32'(hi[1]), 32'd6);
    chk("t5_d2_dark", 32'(hi[2]), 32'd0);
    chk("t5_d3_lit", 32'(hi[3]), 32'd6);

    // Hex decode table, one nibble per frame.
    for (int i = 0; i < 16; i++) begin
      en = 1'b0;
      step();
      do_write({4{vecs[i].nib}}, {4{vecs[i].dp}}, 4'b0000);
      en = 1'b1;
      run_until_dig(4'b0001, "hex_reach_d0");
      chk("hex_seg", 32'(seg), 32'(vecs[i].exp_seg));
    end

    // Asynchronous reset with a write pending, mid-SHOW.
    run_until_dig(4'b0010, "t1_reach_d1");
    do_write(16'h5555, 4'b1111, 4'b0000);
    chk("t1_pre_ready", 32'(wr_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_seg", 32'(seg), 32'h00);
    chk("t1_dig", 32'(dig), 32'h0);
    chk("t1_ready", 32'(wr_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      wr_valid = ($urandom_range(0, 15) == 0);
      wr_data  = 16'($urandom);
      wr_dp    = 4'($urandom);
      wr_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end
    wr_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
